bank_sched: RTL and testbench



---
 rtl/bank_sched_if.sv | 20 ++
 rtl/bank_sched.sv | 111 +++++++++++
 tb/tb_bank_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_sched_if.sv
// Control handshake and bank-port bundle between the NTT bank scheduler and its environment.
interface bank_sched_if #(
    parameter int DEPTH_LOG = 5
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [2:0]           stage;
    logic                 ien;
    logic                 ren;
    logic [DEPTH_LOG-1:0] ra;
    logic                 wen;
    logic [DEPTH_LOG-1:0] wa;
    logic                 q_vld;

    modport master (output start,
                    input  busy, done, stage, ien, ren, ra, wen, wa, q_vld);
    modport slave  (input  start,
                    output busy, done, stage, ien, ren, ra, wen, wa, q_vld);
endinterface

// File: rtl/bank_sched.sv
// Runs one coefficient bank through STAGES in-place passes: rotated reads, write-back after the
// butterfly latency, and a drain between passes so no address is read while its write is in flight.
module bank_sched #(
    parameter int DEPTH_LOG = 5,
    parameter int STAGES    = 5,
    parameter int PIPE_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    bank_sched_if.slave bus
);
    localparam int W  = PIPE_LAT + 1;
    localparam int DW = (W > 1) ? $clog2(W) : 1;
    localparam logic [DEPTH_LOG-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]           LAST_STAGE = 3'(STAGES - 1);
    localparam logic [DW-1:0]        LAST_DRAIN = DW'(W - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t               state, state_nxt;
    logic [DEPTH_LOG-1:0] cnt, cnt_nxt;
    logic [DW-1:0]        dcnt, dcnt_nxt;
    logic [2:0]           stage, stage_nxt;
    logic                 rd;
    logic [DEPTH_LOG-1:0] rd_addr;
    logic [DEPTH_LOG:0]   line [W];
    logic                 vld;
    int                   sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dcnt  <= '0;
            stage <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dcnt  <= dcnt_nxt;
            stage <= stage_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dcnt_nxt  = dcnt;
        stage_nxt = stage;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                end
            end
            READ: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = DRAIN;
                    dcnt_nxt  = '0;
                end
            end
            DRAIN: begin
                dcnt_nxt = dcnt + 1'b1;
                if (dcnt == LAST_DRAIN) begin
                    if (stage == LAST_STAGE) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = READ;
                        stage_nxt = stage + 3'd1;
                        cnt_nxt   = '0;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
                stage_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A shift by DEPTH_LOG or more yields zero, so stage 0 degenerates to the natural order.
    always_comb begin
        sh      = int'(stage) % DEPTH_LOG;
        rd      = (state == READ);
        rd_addr = rd ? ((cnt << sh) | (cnt >> (DEPTH_LOG - sh))) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) line[i] <= '0;
            vld <= 1'b0;
        end else begin
            line[0] <= {rd, rd_addr};
            for (int i = 1; i < W; i++) line[i] <= line[i-1];
            vld <= rd;
        end
    end

    assign bus.ren   = rd;
    assign bus.ra    = rd_addr;
    assign bus.wen   = line[W-1][DEPTH_LOG];
    assign bus.wa    = line[W-1][DEPTH_LOG-1:0];
    assign bus.ien   = rd | line[W-1][DEPTH_LOG];
    assign bus.q_vld = vld;
    assign bus.busy  = (state == READ) || (state == DRAIN);
    assign bus.done  = (state == FIN);
    assign bus.stage = stage;
endmodule

// File: tb/tb_bank_sched.sv
// Directed bench for bank_sched: a default-parameter instance plus a PIPE_LAT=0/STAGES=1 instance.
module tb_bank_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    bank_sched_if #(.DEPTH_LOG(5)) bus ();
    bank_sched_if #(.DEPTH_LOG(5)) bus0 ();

    bank_sched #(.DEPTH_LOG(5), .STAGES(5), .PIPE_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    bank_sched #(.DEPTH_LOG(5), .STAGES(1), .PIPE_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    function automatic logic [4:0] rotl5(logic [4:0] v, int s);
        logic [4:0] r = v;
        for (int i = 0; i < s; i++) r = {r[3:0], r[4]};
        return r;
    endfunction

    // {valid, addr} of the read issued in cycle n of a default run started in cycle 0.
    function automatic logic [5:0] rd_at(int n);
        int k;
        int off;
        if (n < 1 || n > 185) return 6'd0;
        k   = (n - 1) / 37;
        off = (n - 1) % 37;
        if (off >= 32) return 6'd0;
        return {1'b1, rotl5(5'(off), k % 5)};
    endfunction

    function automatic logic [18:0] outs_main();
        return {bus.busy, bus.done, bus.stage, bus.ien, bus.ren, bus.ra,
                bus.wen, bus.wa, bus.q_vld};
    endfunction

    function automatic logic [18:0] outs_lat0();
        return {bus0.busy, bus0.done, bus0.stage, bus0.ien, bus0.ren, bus0.ra,
                bus0.wen, bus0.wa, bus0.q_vld};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            compared++;
            if (outs_main() !== 19'd0 || outs_lat0() !== 19'd0) begin
                mismatched++;
                $display("FAIL reset_hold cycle %0d: got %h/%h required 0/0", n, outs_main(), outs_lat0());
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            compared++;
            if (outs_main() !== 19'd0 || outs_lat0() !== 19'd0) begin
                mismatched++;
                $display("FAIL idle cycle %0d: got %h/%h required 0/0", n, outs_main(), outs_lat0());
            end
        end
    endtask

    task automatic test_single_run();
        logic [11:0] mem  [32];
        logic [11:0] init [32];
        int          wcount [32];
        logic [16:0] fifo [$];
        logic [16:0] ent;
        logic [5:0]  er;
        logic [5:0]  ew;
        logic [5:0]  eq;
        logic [18:0] exp_v;
        for (int i = 0; i < 32; i++) begin
            init[i]   = 12'(i * 37 + 5);
            mem[i]    = init[i];
            wcount[i] = 0;
        end
        @(posedge clk);
        #1 bus.start = 1'b1;
        for (int n = 0; n <= 190; n++) begin
            @(negedge clk);
            er = rd_at(n);
            ew = rd_at(n - 5);
            eq = rd_at(n - 1);
            exp_v = {(n >= 1 && n <= 185), (n == 186),
                     (er[5] ? 3'((n - 1) / 37) : bus.stage),
                     er[5] | ew[5], er[5], er[4:0], ew[5], ew[4:0], eq[5]};
            compared++;
            if (outs_main() !== exp_v) begin
                mismatched++;
                $display("FAIL run cycle %0d: got %h required %h", n, outs_main(), exp_v);
            end
            if (bus.ren) fifo.push_back({bus.ra, 12'(mem[bus.ra] + 12'd1)});
            if (bus.wen) begin
                if (fifo.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_underflow cycle %0d: got write to %0d required none", n, bus.wa);
                end else begin
                    ent = fifo.pop_front();
                    compared++;
                    if (bus.wa !== ent[16:12]) begin
                        mismatched++;
                        $display("FAIL sb_waddr cycle %0d: got %0d required %0d", n, bus.wa, ent[16:12]);
                    end
                    mem[bus.wa] = ent[11:0];
                    wcount[bus.wa]++;
                end
            end
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            compared++;
            if (mem[i] !== 12'(init[i] + 12'd5) || wcount[i] != 5) begin
                mismatched++;
                $display("FAIL sb_entry %0d: got value %h writes %0d required value %h writes 5",
                         i, mem[i], wcount[i], 12'(init[i] + 12'd5));
            end
        end
        compared++;
        if (fifo.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover: got %0d pending required 0", fifo.size());
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt   = 0;
        int done_cyc   = -1;
        int wen_cnt    = 0;
        @(posedge clk);
        #1 bus.start = 1'b1;
        for (int n = 0; n <= 200; n++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                done_cyc = n;
            end
            if (bus.wen) wen_cnt++;
            @(posedge clk);
            #1 bus.start = (n + 1 == 10) || (n + 1 == 100);
        end
        compared++;
        if (done_cnt != 1 || done_cyc != 186) begin
            mismatched++;
            $display("FAIL ignore_start_done: got %0d pulses last at %0d required 1 at 186", done_cnt, done_cyc);
        end
        compared++;
        if (wen_cnt != 160) begin
            mismatched++;
            $display("FAIL ignore_start_writes: got %0d required 160", wen_cnt);
        end
    endtask

    task automatic test_midrun_reset();
        int ren_cnt   = 0;
        int busy_cnt  = 0;
        int first_ren = -1;
        int done_cyc  = -1;
        logic [4:0] first_ra = '1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        compared++;
        if (bus.busy !== 1'b1 || bus.stage !== 3'd1) begin
            mismatched++;
            $display("FAIL pre_reset_state: got busy %b stage %0d required busy 1 stage 1", bus.busy, bus.stage);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (outs_main() !== 19'd0) begin
            mismatched++;
            $display("FAIL midrun_reset_same_cycle: got %h required 0", outs_main());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        for (int n = 0; n <= 190; n++) begin
            @(negedge clk);
            if (bus.ren) begin
                ren_cnt++;
                if (first_ren < 0) begin
                    first_ren = n;
                    first_ra  = bus.ra;
                end
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cyc = n;
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        compared++;
        if (first_ren != 1 || first_ra !== 5'd0 || ren_cnt != 160) begin
            mismatched++;
            $display("FAIL rerun_reads: got first %0d ra %0d count %0d required first 1 ra 0 count 160",
                     first_ren, first_ra, ren_cnt);
        end
        compared++;
        if (done_cyc != 186 || busy_cnt != 185) begin
            mismatched++;
            $display("FAIL rerun_timing: got done %0d busy %0d required done 186 busy 185", done_cyc, busy_cnt);
        end
    endtask

    task automatic test_pipe_lat0();
        logic [18:0] exp_v;
        logic        er;
        logic        ew;
        @(posedge clk);
        #1 bus0.start = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            er = (n >= 1 && n <= 32);
            ew = (n >= 2 && n <= 33);
            exp_v = {(n >= 1 && n <= 33), (n == 34), 3'd0, er | ew,
                     er, (er ? 5'(n - 1) : 5'd0), ew, (ew ? 5'(n - 2) : 5'd0), ew};
            compared++;
            if (outs_lat0() !== exp_v) begin
                mismatched++;
                $display("FAIL lat0 cycle %0d: got %h required %h", n, outs_lat0(), exp_v);
            end
            @(posedge clk);
            #1 bus0.start = 1'b0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus0.start = 1'b0;
        test_reset();
        test_single_run();
        test_ignore_start();
        test_midrun_reset();
        test_pipe_lat0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
